// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: ready/valid fetch port with programmable wait states and a preload write port.
// Optional address checking is enabled by defining IMEM_ADDR_CHECK_EN.
module instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        start_read,
    output logic        ready,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        rsp_error,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned WCW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0]    mem [DEPTH_WORDS];

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           ready_q, ready_d;
    logic           valid_q, valid_d;
    logic [31:0]    instr_q, instr_d;
    logic [AW-1:0]  rd_idx;
    logic           enter_resp;

    // Byte address to word index; wraps modulo DEPTH_WORDS, low two bits dropped.
    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

`ifdef IMEM_ADDR_CHECK_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic fault_q, fault_d;
    logic err_q, err_d;
    logic rd_fault;
    logic load_ok;

    // Misaligned, below base, or beyond the last word (33-bit math avoids overflow).
    function automatic logic addr_fault(input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (addr[1:0] != 2'b00) || off[32] || (off >= SPAN);
    endfunction

    assign rd_fault  = (state_q == S_IDLE) ? addr_fault(pc) : fault_q;
    assign load_ok   = load_en && !addr_fault(load_addr);
    assign rsp_error = err_q;
`else
    logic load_ok;

    assign load_ok   = load_en;
    assign rsp_error = 1'b0;
`endif

    // With zero wait states the array is read on the accept edge, so index straight from pc.
    assign rd_idx = (state_q == S_IDLE) ? word_idx(pc) : idx_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        instr_d    = instr_q;
        enter_resp = 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
        fault_d    = fault_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_read) begin
                    idx_d = word_idx(pc);
`ifdef IMEM_ADDR_CHECK_EN
                    fault_d = addr_fault(pc);
`endif
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WCW'(WAIT_STATES - 1);
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // mem holds pre-edge contents here, giving read-before-write on a same-edge preload.
        if (enter_resp) begin
`ifdef IMEM_ADDR_CHECK_EN
            instr_d = rd_fault ? NOP : mem[rd_idx];
            err_d   = rd_fault;
`else
            instr_d = mem[rd_idx];
`endif
        end

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
`ifdef IMEM_ADDR_CHECK_EN
            fault_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
`ifdef IMEM_ADDR_CHECK_EN
            fault_q <= fault_d;
            err_q   <= err_d;
`endif
        end
    end

    // Preload port: independent of the read FSM and untouched by reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[word_idx(load_addr)] <= load_data;
        end
    end

    assign ready       = ready_q;
    assign instr_valid = valid_q;
    assign instruction = instr_q;

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder serving the fetch side of the RISC-V pipeline CPU. It answers the CPU's `pc_out`/`start_read` fetch requests with the 32-bit instruction word. It uses a ready/valid handshake, a programmable number of wait states, and a byte-addressed preload write port for program loading. It sits outside the CPU top, between the fetch request lines and `instruction_out`.

## Interface
- `DEPTH_WORDS`, 256: memory size in 32-bit words; power of two, 16..4096.
- `WAIT_STATES`, 2: extra latency cycles per read; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in 32: fetch byte address; sampled on the accept edge.
- `start_read` in 1: read request strobe.
- `ready` out 1: responder can accept a request.
- `instruction` out 32: returned instruction word; holds its value between responses.
- `instr_valid` out 1: one-cycle pulse; `instruction` is valid.
- `rsp_error` out 1: qualified by `instr_valid`; address fault (see Configuration).
- `load_en` in 1: preload write strobe.
- `load_addr` in 32: preload byte address.
- `load_data` in 32: preload word.

## Operation
- Word index: `idx = (addr - BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits, so it wraps modulo DEPTH_WORDS. Address bits [1:0] are ignored.
- A request is accepted on the rising edge where `start_read && ready`. `start_read` while `ready` is low is ignored and not queued; fetch must hold or re-issue the request.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `ready` is 1. On accept, capture the index and the fault flag. Go to WAIT with `wcnt = WAIT_STATES-1` if WAIT_STATES > 0, else go directly to RESP.
  - WAIT: `ready` is 0. Decrement `wcnt`; when `wcnt` is 0, go to RESP.
  - RESP: `ready` is 0, `instr_valid` is 1. Unconditionally return to IDLE on the next edge.
- `instruction` and `rsp_error` are registered on the edge that enters RESP, reading `mem[idx]` at that edge.
- Preload: when `load_en` is 1, `mem[idx(load_addr)] <= load_data` on the edge. Writes are accepted in every state and are independent of the read FSM.
- Load/read collision: if a preload hits the same word on the edge that enters RESP, the read returns the pre-write data (read-before-write). A write on any earlier edge of the transaction is visible to that read.
- Memory contents are not affected by `rst`.

## Timing
- Reset values, one cycle after `rst` is sampled high: state IDLE, `ready`=1, `instr_valid`=0, `instruction`=32'h0, `rsp_error`=0, `wcnt`=0.
- Reset mid-transaction, in WAIT or RESP: the pending request is dropped, with no `instr_valid`. `ready` is 1 in the cycle after reset.
- A request accepted at the end of cycle N gives `instr_valid` in cycle N+1+WAIT_STATES. `ready` is low from N+1 through that cycle and is high again in N+2+WAIT_STATES.
- Maximum throughput: one request per WAIT_STATES+2 cycles.
- `ready` is a pure function of the state register; it has no combinational path from `start_read`.

## Configuration
- `IMEM_ADDR_CHECK_EN` defined:
  - A read whose `pc` is misaligned (`pc[1:0]` != 0), below BASE_ADDR, or at/above BASE_ADDR + 4*DEPTH_WORDS completes with normal latency. It returns `instruction` = 32'h0000_0013 (NOP) with `rsp_error`=1, and the array is not read.
  - Preloads that are out of range or misaligned are dropped.
- `IMEM_ADDR_CHECK_EN` undefined:
  - Addresses wrap and low bits are ignored.
  - `rsp_error` is tied to 0, and the range/alignment logic is not compiled.

## Test plan
- Reset then basic read: `rst` for 2 cycles. Preload 0x0 = 32'h0050_0093. `start_read` at pc=0x0 with WAIT_STATES=2 gives `instr_valid` exactly 3 cycles after the accept cycle, with `instruction` = 32'h0050_0093. `ready` is low for 3 cycles.
- Zero wait states: rebuild with WAIT_STATES=0. Back-to-back requests to pc=0x4 and pc=0x8 give valid pulses 2 cycles apart, carrying each word in order. `start_read` held during the RESP cycle is ignored.
- Collision: request pc=0x10, whose word holds 32'hAAAA_AAAA. A preload of 32'hBBBB_BBBB to 0x10 on the RESP-entry edge returns 32'hAAAA_AAAA; a repeat read returns 32'hBBBB_BBBB.
- Reset mid-read: `rst` asserted during WAIT gives no `instr_valid`, `ready`=1 and `instruction`=0 the next cycle, and memory retains its preloaded words.
- Wrap, macro off: with DEPTH_WORDS=256, read pc=0x400 returns the word at 0x0 with `rsp_error`=0. Read pc=0x6 returns the word at 0x4.
- Fault, `IMEM_ADDR_CHECK_EN` on: read pc=0x400 and read pc=0x6 each return 32'h0000_0013 with `rsp_error`=1 and normal latency. A preload to 0x400 leaves word 0 unchanged.
